// File: rtl/jt12_pm_mix_pkg.sv
// Shared constants, stage bundle and PM arithmetic for the jt12 phase-modulation mixer.
package jt12_pm_mix_pkg;

    localparam int OP_W    = 14;
    localparam int PM_W    = 10;
    localparam int SUM_W   = 15;
    localparam int FB_BASE = 10;

    localparam logic [1:0] OP_S1 = 2'd0;
    localparam logic [1:0] OP_S2 = 2'd1;
    localparam logic [1:0] OP_S3 = 2'd2;
    localparam logic [1:0] OP_S4 = 2'd3;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_S1,
        SLOT_HALF
    } slot_e;

    typedef struct packed {
        logic [OP_W-1:0] x;
        logic [OP_W-1:0] y;
        slot_e           slot;
        logic [2:0]      fb;
    } stage_a_t;

    function automatic logic [PM_W-1:0] pm_calc(input stage_a_t a);
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] sh;
        logic [3:0]              amt;
        logic [PM_W-1:0]         pm;
        sum = {a.x[OP_W-1], a.x} + {a.y[OP_W-1], a.y};
        amt = 4'(FB_BASE) - {1'b0, a.fb};
        sh  = sum >>> amt;
        pm  = '0;
        case (a.slot)
            SLOT_S1: begin
                if (a.fb != 3'd0)
                    pm = sh[PM_W-1:0];
            end
            SLOT_HALF: pm = sum[PM_W:1];
            default:   pm = '0;
        endcase
        return pm;
    endfunction

endpackage

// File: rtl/jt12_pm_hist.sv
// Per-channel operator history file with write-first bypass and S1 shift chain.
module jt12_pm_hist
    import jt12_pm_mix_pkg::*;
#(
    parameter int num_ch = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            we,
    input  logic [1:0]      op,
    input  logic [2:0]      wch,
    input  logic [OP_W-1:0] din,
    input  logic [2:0]      rch,
    output logic [OP_W-1:0] prev1,
    output logic [OP_W-1:0] prevprev1,
    output logic [OP_W-1:0] prev2,
    output logic [OP_W-1:0] int3
);

    localparam logic [3:0] NCH = 4'(num_ch);

    logic [OP_W-1:0] p1_q  [8];
    logic [OP_W-1:0] pp1_q [8];
    logic [OP_W-1:0] p2_q  [8];
    logic [OP_W-1:0] i3_q  [8];

    logic wr_ok;
    logic rd_ok;
    logic hit;

    assign wr_ok = we && ({1'b0, wch} < NCH);
    assign rd_ok = {1'b0, rch} < NCH;
    assign hit   = clk_en && wr_ok && (wch == rch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                p1_q[c]  <= '0;
                pp1_q[c] <= '0;
                p2_q[c]  <= '0;
                i3_q[c]  <= '0;
            end
        end else if (clk_en && wr_ok) begin
            case (op)
                OP_S1: begin
                    pp1_q[wch] <= p1_q[wch];
                    p1_q[wch]  <= din;
                end
                OP_S2:   p2_q[wch] <= din;
                OP_S3:   i3_q[wch] <= din;
                default: ;
            endcase
        end
    end

    // Same-slot write must be visible to the reader, including the S1 shift.
    always_comb begin
        prev1     = p1_q[rch];
        prevprev1 = pp1_q[rch];
        prev2     = p2_q[rch];
        int3      = i3_q[rch];
        if (hit) begin
            case (op)
                OP_S1: begin
                    prevprev1 = p1_q[rch];
                    prev1     = din;
                end
                OP_S2:   prev2 = din;
                OP_S3:   int3  = din;
                default: ;
            endcase
        end
        if (!rd_ok) begin
            prev1     = '0;
            prevprev1 = '0;
            prev2     = '0;
            int3      = '0;
        end
    end

endmodule

// File: rtl/jt12_pm_mix.sv
// Phase-modulation mixer: operand select, overuse check and two-stage PM pipeline.
module jt12_pm_mix
    import jt12_pm_mix_pkg::*;
#(
    parameter int num_ch = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            s1_enters,
    input  logic            s2_enters,
    input  logic            s3_enters,
    input  logic            s4_enters,
    input  logic [2:0]      ch,
    input  logic [2:0]      fb_II,
    input  logic            xuse_prevprev1,
    input  logic            xuse_prev2,
    input  logic            xuse_internal,
    input  logic            yuse_prev1,
    input  logic            yuse_prev2,
    input  logic            yuse_internal,
    input  logic            res_we,
    input  logic [1:0]      res_op,
    input  logic [2:0]      res_ch,
    input  logic [OP_W-1:0] op_result,
    output logic [PM_W-1:0] pm_out,
    output logic            pm_valid,
    output logic            use_err
);

    logic [OP_W-1:0] prev1;
    logic [OP_W-1:0] prevprev1;
    logic [OP_W-1:0] prev2;
    logic [OP_W-1:0] int3;

    jt12_pm_hist #(
        .num_ch (num_ch)
    ) u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .we        (res_we),
        .op        (res_op),
        .wch       (res_ch),
        .din       (op_result),
        .rch       (ch),
        .prev1     (prev1),
        .prevprev1 (prevprev1),
        .prev2     (prev2),
        .int3      (int3)
    );

    // Y may only tap S2 history on the 3-channel variant.
    logic y_p2;
    assign y_p2 = (num_ch == 3) && yuse_prev2;

    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
    logic            over_x;
    logic            over_y;
    slot_e           slot;
    stage_a_t        nxt_a;
    stage_a_t        st_a;

    always_comb begin
        x = ({OP_W{xuse_prevprev1}} & prevprev1)
          | ({OP_W{xuse_prev2}}     & prev2)
          | ({OP_W{xuse_internal}}  & int3);
        y = ({OP_W{yuse_prev1}}    & prev1)
          | ({OP_W{y_p2}}          & prev2)
          | ({OP_W{yuse_internal}} & int3);
        over_x = (xuse_prevprev1 & xuse_prev2)
               | (xuse_prevprev1 & xuse_internal)
               | (xuse_prev2 & xuse_internal);
        over_y = (yuse_prev1 & y_p2)
               | (yuse_prev1 & yuse_internal)
               | (y_p2 & yuse_internal);
        slot = SLOT_NONE;
        if (s1_enters)
            slot = SLOT_S1;
        else if (s2_enters | s3_enters | s4_enters)
            slot = SLOT_HALF;
        nxt_a.x    = x;
        nxt_a.y    = y;
        nxt_a.slot = slot;
        nxt_a.fb   = fb_II;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_a     <= '0;
            pm_out   <= '0;
            pm_valid <= 1'b0;
            use_err  <= 1'b0;
        end else if (clk_en) begin
            st_a     <= nxt_a;
            pm_out   <= pm_calc(st_a);
            pm_valid <= (st_a.slot != SLOT_NONE);
            use_err  <= use_err | over_x | over_y;
        end
    end

endmodule

// File: doc/jt12_pm_mix.md
# jt12_pm_mix

Phase-modulation mixer sitting directly downstream of the operator-routing decoder (`xuse_*` / `yuse_*` flags). It keeps a per-channel history of operator outputs. Each slot it selects the X and Y modulation operands named by the decoder flags, sums them and scales the sum (S1 self-feedback scaling by FB level, or plain halving for S2–S4). It delivers a registered 10-bit phase-modulation word to the phase adder of the operator pipeline.

## Interface
Parameters:
- `num_ch`, 6, channel count; legal values are 6 or 3. `yuse_prev2` is honoured only when `num_ch==3` and is ignored when 6.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `clk_en`  in  1  slot advance; all state updates only when high
- `s1_enters`/`s2_enters`/`s3_enters`/`s4_enters`  in  1 each  operator of the slot being read (one-hot or all 0)
- `ch`  in  3  channel of the slot being read
- `fb_II`  in  3  feedback level of `ch`
- `xuse_prevprev1`, `xuse_prev2`, `xuse_internal`  in  1 each  X operand selects
- `yuse_prev1`, `yuse_prev2`, `yuse_internal`  in  1 each  Y operand selects
- `res_we`  in  1  operator result write strobe
- `res_op`  in  2  operator of result (0=S1, 1=S2, 2=S3, 3=S4)
- `res_ch`  in  3  channel of result
- `op_result`  in  14  signed operator output
- `pm_out`  out  10  signed phase modulation
- `pm_valid`  out  1  `pm_out` updated this `clk_en`
- `use_err`  out  1  sticky operand-overuse flag

## Operation
- **History registers, per channel `c < num_ch`:**
  - `prev1[c]`: last S1 result.
  - `prevprev1[c]`: S1 result before that.
  - `prev2[c]`: last S2 result.
  - `int3[c]`: last S3 result.
- **Write, on `clk_en & res_we`:**
  - `res_op=0`: `prevprev1 <= prev1`, `prev1 <= op_result`.
  - `res_op=1`: update `prev2`.
  - `res_op=2`: update `int3`.
  - `res_op=3`: no storage.
  - `res_ch >= num_ch`: write ignored.
- **Read operands:**
  - X = OR of (`xuse_prevprev1`?`prevprev1`, `xuse_prev2`?`prev2`, `xuse_internal`?`int3`).
  - Y = OR of (`yuse_prev1`?`prev1`, `yuse_prev2`?`prev2` when `num_ch==3`, `yuse_internal`?`int3`).
  - An unselected operand is 0. `ch >= num_ch` gives X=Y=0.
- **Write-first bypass:** a read in the same `clk_en` as a write to the same channel sees post-write values, including the `prevprev1` shift.
- **Overuse:** more than one X select or more than one Y select at a `clk_en` sets `use_err`. The OR-combined operands are still used. `use_err` clears only on reset.
- **Arithmetic:** `sum` = sign-extended X + Y, 15 bits, never overflows.
  - S1 slot, `fb_II==0`: `pm = 0`.
  - S1 slot, otherwise: `pm = (sum >>> (10-fb_II))[9:0]` (arithmetic shift).
  - S2/S3/S4 slot: `pm = sum[10:1]`.
  - No slot flag set: `pm = 0`.
- **S3 of algorithm 5:** reading `prevprev1` yields the S1 output one sample older than S4 sees. This is the required behaviour.

## Timing
- **Stage A** (`clk_en` edge N): operands, slot type and `fb_II` are latched into pipeline registers.
- **Stage B** (`clk_en` edge N+1): `pm_out` is registered and `pm_valid` is high for that `clk_en` cycle.
- Latency is 2 `clk_en` edges. Throughput is one slot per `clk_en`.
- `pm_valid` pulses high for exactly one `clk_en` period per input slot that had a slot flag. It is low after reset until the first slot reaches stage B.
- When `clk_en` is low, all registers hold and the outputs are stable.
- **Reset** (`rst_n` low, any time, asynchronous):
  - All history and pipeline registers go to 0.
  - `pm_out = 0`, `pm_valid = 0`, `use_err = 0`.
  - A slot in flight is discarded. The first output after release corresponds to the first slot read after release.

## Structure
- A shared package holds the operator code constants (S1..S4 = 0..3), widths (OP_W=14, PM_W=10, SUM_W=15) and the FB base shift constant 10.
- Sub-module `jt12_pm_hist` contains the per-channel register file with write-first bypass and the `prevprev1` shift.
- The top level holds operand muxing, the overuse check and the two-stage arithmetic pipeline.

## Test plan
- **Reset:** write S1=0x1000 to ch0, read ch0 S1 with fb=7, assert `rst_n` low mid-pipeline -> `pm_out=0`, `pm_valid=0`, `use_err=0`. After release, all history reads return 0.
- **Feedback:** write S1 results 0x0400 then 0x0200 to ch2, read S1 ch2 with x=prevprev1, y=prev1:
  - fb=7 -> `pm_out` = 0x600>>>3 = 0x0C0 two `clk_en` later.
  - fb=0 -> `pm_out=0`.
- **Negative halving:** S2=-8192 stored in ch1, S4 read with `xuse_prev2` only -> `pm_out` = -4096[10:1] = 10'h000. Same with S2=-100 -> `pm_out` = -50 (10'h3CE).
- **Bypass:** in the same `clk_en`, write S3=0x0100 to ch4 and read S4 ch4 with `yuse_internal` -> `pm_out`=0x080. Write to ch5 instead -> old value used.
- **num_ch=3:** `yuse_prev2` selects prev2 -> summed correctly. Under `num_ch=6` the same stimulus yields Y=0. `ch=3` reads and writes are ignored.
- **Overuse:** `xuse_prev2` and `xuse_internal` high together -> `use_err` rises after the edge and stays high through further clean slots until reset.
